// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the write-back / register-file slice.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: one synchronous write port, three raw
// combinational read ports, every entry cleared by the asynchronous reset.
// Zero-register and bypass policy live in the parent; the core stores whatever
// it is told to store.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [ADDR_W-1:0] raddr_c,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update: reset clears every entry, otherwise commit the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus register file: selects the write-back value, commits
// it to storage, serves two bypassed ID read ports and a raw debug port, and
// counts committed writes with a saturating counter.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic              wb_mem_to_reg,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

  logic [DATA_W-1:0] raw_rs;
  logic [DATA_W-1:0] raw_rt;

  // A write to r0 is not a commit: it neither reaches storage nor counts.
  assign wb_data   = wb_mem_to_reg ? wb_read_data : wb_alu_result;
  assign wb_commit = wb_reg_write && (wb_write_reg != ZERO_IDX);

  regfile_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_commit),
    .waddr   (wb_write_reg),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .raddr_c (dbg_addr),
    .rdata_a (raw_rs),
    .rdata_b (raw_rt),
    .rdata_c (dbg_data)
  );

  // ID read ports: r0 reads zero, a same-cycle commit to the same index is
  // forwarded when bypass is enabled, otherwise the stored value is returned.
  always_comb begin
    rs_data = raw_rs;
    rt_data = raw_rt;
    if (BYPASS && wb_commit && (rs_addr == wb_write_reg)) begin
      rs_data = wb_data;
    end
    if (BYPASS && wb_commit && (rt_addr == wb_write_reg)) begin
      rt_data = wb_data;
    end
    if (rs_addr == ZERO_IDX) begin
      rs_data = '0;
    end
    if (rt_addr == ZERO_IDX) begin
      rt_data = '0;
    end
  end

  // Committed-write counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (wb_commit && (wr_count != 32'hFFFF_FFFF)) begin
      wr_count <= wr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array-based architectural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_data;
  logic [4:0]  wb_write_reg;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs_data, rt_data, wb_data, dbg_data, wr_count;
  logic        wb_commit;
  logic [31:0] rs_data_nb, rt_data_nb, wb_data_nb, dbg_data_nb, wr_count_nb;
  logic        wb_commit_nb;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_write_reg(wb_write_reg), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
    .wb_commit(wb_commit), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  wb_regfile #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_write_reg(wb_write_reg), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data_nb), .rt_data(rt_data_nb), .wb_data(wb_data_nb),
    .wb_commit(wb_commit_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb),
    .wr_count(wr_count_nb)
  );

  function automatic logic [31:0] m_wb();
    return wb_mem_to_reg ? wb_read_data : wb_alu_result;
  endfunction

  function automatic bit m_commit();
    return wb_reg_write && (wb_write_reg != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && m_commit() && (a == wb_write_reg)) return m_wb();
    return mregs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 32'd0;
  endtask

  task automatic set_in(input logic [31:0] alu, input logic [31:0] rd,
                        input logic [4:0] wreg, input logic m2r, input logic we,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dbg);
    wb_alu_result = alu;
    wb_read_data  = rd;
    wb_write_reg  = wreg;
    wb_mem_to_reg = m2r;
    wb_reg_write  = we;
    rs_addr       = rs;
    rt_addr       = rt;
    dbg_addr      = dbg;
  endtask

  // Clock edge with reset low: apply the architectural write to the model.
  task automatic step_commit();
    @(posedge clk);
    if (m_commit()) begin
      mregs[wb_write_reg] = m_wb();
      if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    m_clear();
    #2;
    vectors++;
    if (wr_count !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_wr_count: got %h expected %h", wr_count, 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      rs_addr  = 5'(i);
      #0.1;
      vectors++;
      if (dbg_data !== 32'd0 || rs_data !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_reg r%0d: dbg %h rs %h expected 0", i, dbg_data, rs_data);
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    set_in(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5);
    step_commit();
    @(negedge clk);
    wb_reg_write = 1'b0;
    #1;
    vectors++;
    if (dbg_data !== 32'h0000_1234) begin
      miscompares++;
      $display("[TB] FAIL midrun_preload: got %h expected %h", dbg_data, 32'h0000_1234);
    end
    reset = 1'b1;
    m_clear();
    #1;
    vectors++;
    if (dbg_data !== 32'd0 || wr_count !== 32'd0 || rs_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_async_clear: dbg %h cnt %h rs %h expected 0", dbg_data, wr_count, rs_data);
    end
    @(negedge clk);
    set_in(32'h0000_FFFF, 32'h0, 5'd6, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wb_reg_write = 1'b0;
    #1;
    vectors++;
    if (dbg_data !== 32'd0 || wr_count !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL write_during_reset: dbg %h cnt %h expected 0", dbg_data, wr_count);
    end
  endtask

  task automatic test_mem_to_reg();
    @(negedge clk);
    set_in(32'hAAAA_0000, 32'h5555_FFFF, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
    #1;
    vectors++;
    if (wb_data !== 32'h5555_FFFF || wb_commit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mem_to_reg_sel: wb_data %h commit %b expected 5555ffff 1", wb_data, wb_commit);
    end
    wb_mem_to_reg = 1'b0;
    #1;
    vectors++;
    if (wb_data !== 32'hAAAA_0000) begin
      miscompares++;
      $display("[TB] FAIL alu_sel: got %h expected aaaa0000", wb_data);
    end
    wb_mem_to_reg = 1'b1;
    step_commit();
    vectors++;
    if (dbg_data !== 32'h5555_FFFF || wr_count !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL mem_to_reg_commit: dbg %h cnt %h expected 5555ffff 1", dbg_data, wr_count);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    set_in(32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    vectors++;
    if (wb_commit !== 1'b0 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL zero_same_cycle: commit %b rs %h rt %h expected 0", wb_commit, rs_data, rt_data);
    end
    step_commit();
    vectors++;
    if (rs_data !== 32'd0 || dbg_data !== 32'd0 || wr_count !== mcnt) begin
      miscompares++;
      $display("[TB] FAIL zero_after: rs %h dbg %h cnt %h expected 0 0 %h", rs_data, dbg_data, wr_count, mcnt);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    set_in(32'h1111_0000, 32'h0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7);
    step_commit();
    @(negedge clk);
    set_in(32'hCAFE_F00D, 32'h0, 5'd7, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
    #1;
    vectors++;
    if (rs_data !== 32'hCAFE_F00D || rt_data !== 32'hCAFE_F00D || dbg_data !== 32'h1111_0000) begin
      miscompares++;
      $display("[TB] FAIL bypass_on: rs %h rt %h dbg %h expected cafef00d cafef00d 11110000", rs_data, rt_data, dbg_data);
    end
    vectors++;
    if (rs_data_nb !== 32'h1111_0000 || rt_data_nb !== 32'h1111_0000) begin
      miscompares++;
      $display("[TB] FAIL bypass_off: rs %h rt %h expected 11110000", rs_data_nb, rt_data_nb);
    end
    step_commit();
    @(negedge clk);
    wb_reg_write = 1'b0;
    #1;
    vectors++;
    if (dbg_data !== 32'hCAFE_F00D || rs_data_nb !== 32'hCAFE_F00D || rs_data !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("[TB] FAIL bypass_stored: dbg %h rs_nb %h rs %h expected cafef00d", dbg_data, rs_data_nb, rs_data);
    end
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    set_in(32'h0000_0001, 32'h0, 5'd9, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9);
    #1;
    vectors++;
    if (wb_commit !== 1'b0 || rs_data !== mregs[9]) begin
      miscompares++;
      $display("[TB] FAIL wr_disabled_comb: commit %b rs %h expected 0 %h", wb_commit, rs_data, mregs[9]);
    end
    step_commit();
    vectors++;
    if (dbg_data !== mregs[9] || wr_count !== mcnt) begin
      miscompares++;
      $display("[TB] FAIL wr_disabled: dbg %h cnt %h expected %h %h", dbg_data, wr_count, mregs[9], mcnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wreg;
      @(negedge clk);
      wreg = 5'($urandom_range(0, 15));
      set_in($urandom, $urandom, wreg, 1'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0) ? wreg : 5'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? wreg : 5'($urandom_range(0, 15)),
             5'($urandom_range(0, 15)));
      #1;
      vectors++;
      if (wb_data !== m_wb() || wb_commit !== m_commit() || wr_count !== mcnt ||
          dbg_data !== mregs[dbg_addr] || dbg_data_nb !== mregs[dbg_addr]) begin
        miscompares++;
        $display("[TB] FAIL rand_wb[%0d]: wb %h/%h commit %b/%b cnt %h/%h dbg %h/%h",
                 n, wb_data, m_wb(), wb_commit, m_commit(), wr_count, mcnt, dbg_data, mregs[dbg_addr]);
      end
      vectors++;
      if (rs_data !== m_read(rs_addr, 1'b1) || rt_data !== m_read(rt_addr, 1'b1) ||
          rs_data_nb !== m_read(rs_addr, 1'b0) || rt_data_nb !== m_read(rt_addr, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL rand_read[%0d]: rs %h/%h rt %h/%h rs_nb %h/%h rt_nb %h/%h", n,
                 rs_data, m_read(rs_addr, 1'b1), rt_data, m_read(rt_addr, 1'b1),
                 rs_data_nb, m_read(rs_addr, 1'b0), rt_data_nb, m_read(rt_addr, 1'b0));
      end
      step_commit();
    end
  endtask

  task automatic test_saturation();
    logic [31:0] expected;
    @(negedge clk);
    wb_reg_write = 1'b0;
    force dut.wr_count = 32'hFFFF_FFFE;
    #1;
    release dut.wr_count;
    mcnt = 32'hFFFF_FFFE;
    #1;
    vectors++;
    if (wr_count !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("[TB] FAIL sat_preset: got %h expected fffffffe", wr_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in($urandom, $urandom, 5'(k + 10), 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
      step_commit();
      expected = 32'hFFFF_FFFF;
      vectors++;
      if (wr_count !== expected || wr_count !== mcnt) begin
        miscompares++;
        $display("[TB] FAIL sat_commit%0d: got %h expected %h", k, wr_count, expected);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_mem_to_reg();
    test_zero_reg();
    test_bypass();
    test_write_disabled();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
